mux4_rr_arbiter: RTL



---
 rtl/mux4_rr_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and 4:1 mux sequencer with a bounded hold time per owner.
// Define MUX4_ARB_FIXED_PRIO_EN to switch arbitration to fixed priority (index 0 highest).
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       c0,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       z
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_r;
    logic [1:0]  ptr_r;
    logic [1:0]  sel_r;
    logic [7:0]  hcnt_r;
    logic [3:0]  gnt_r;
    logic        busy_r;
    logic [1:0]  pick_s;
    logic [1:0]  cand_s;
    logic [3:0]  c_s;

    // Winner search; candidates are scanned from lowest precedence upward so the last hit wins.
    always_comb begin
        pick_s = 2'd0;
        cand_s = 2'd0;
        for (int k = 3; k >= 0; k--) begin
`ifdef MUX4_ARB_FIXED_PRIO_EN
            cand_s = 2'(k);
`else
            cand_s = ptr_r + 2'(k);
`endif
            if (req[cand_s]) begin
                pick_s = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Grant state machine with registered grant, select and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            sel_r   <= 2'd0;
            hcnt_r  <= 8'd0;
            gnt_r   <= 4'b0000;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        state_r <= GRANT;
                        gnt_r   <= 4'b0001 << pick_s;
                        sel_r   <= pick_s;
                        busy_r  <= 1'b1;
                        hcnt_r  <= 8'd1;
                        ptr_r   <= pick_s + 2'd1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    // Owner dropping its request or reaching the hold bound both release.
                    if (!req[sel_r] || (32'(hcnt_r) >= HOLD_MAX)) begin
                        state_r <= IDLE;
                        gnt_r   <= 4'b0000;
                        busy_r  <= 1'b0;
                        hcnt_r  <= 8'd0;
                    end else begin
                        hcnt_r  <= hcnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= 4'b0000;
                    busy_r  <= 1'b0;
                    hcnt_r  <= 8'd0;
                end
            endcase
        end
    end

    assign c_s  = {c3, c2, c1, c0};
    assign z    = busy_r ? c_s[sel_r] : 1'b0;
    assign gnt  = gnt_r;
    assign s1   = sel_r[1];
    assign s0   = sel_r[0];
    assign busy = busy_r;

endmodule
